// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO with any depth >= 2.
//
// Features: occupancy count, almost-full/almost-empty flags,
// overflow/underflow pulses, standard or first-word-fall-through reads.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   write_en     write request;  data_in  write word
//   read_en      read request / FWFT pop
//   data_out     read word;      data_valid  data_out is meaningful
//   full, empty, almost_full, almost_empty   occupancy flags
//   count        current occupancy
//   overflow     1-cycle pulse after a rejected write
//   underflow    1-cycle pulse after a rejected read
module sync_fifo_flex #(
   parameter int FIFO_DEPTH    = 16,
   parameter int FIFO_WIDTH    = 8,
   parameter int FWFT          = 0,
   parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
   parameter int AEMPTY_THRESH = 2,
   parameter int PTR_WIDTH     = $clog2(FIFO_DEPTH),
   parameter int CNT_WIDTH     = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  write_en,
   input  logic [FIFO_WIDTH-1:0] data_in,
   input  logic                  read_en,
   output logic [FIFO_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [CNT_WIDTH-1:0]  count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [PTR_WIDTH-1:0] LAST_IDX =
      PTR_WIDTH'(FIFO_DEPTH - 1);
   localparam logic [CNT_WIDTH-1:0] MAX_CNT =
      CNT_WIDTH'(FIFO_DEPTH);

   logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_WIDTH-1:0]  r_wr_ptr;
   logic [PTR_WIDTH-1:0]  r_rd_ptr;
   logic [CNT_WIDTH-1:0]  r_count;
   logic                  r_ovf;
   logic                  r_udf;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic [PTR_WIDTH-1:0]  w_wr_ptr_nxt;
   logic [PTR_WIDTH-1:0]  w_rd_ptr_nxt;

   assign w_full   = (r_count == MAX_CNT);
   assign w_empty  = (r_count == '0);
   assign w_wr_acc = write_en & ~w_full;
   assign w_rd_acc = read_en & ~w_empty;

   // Explicit wrap so non-power-of-two depths use every entry
   assign w_wr_ptr_nxt = (r_wr_ptr == LAST_IDX) ? '0
                       : r_wr_ptr + PTR_WIDTH'(1);
   assign w_rd_ptr_nxt = (r_rd_ptr == LAST_IDX) ? '0
                       : r_rd_ptr + PTR_WIDTH'(1);

   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else begin
         r_ovf <= write_en & w_full;
         r_udf <= read_en & w_empty;
         if (w_wr_acc) begin
            r_wr_ptr <= w_wr_ptr_nxt;
         end
         if (w_rd_acc) begin
            r_rd_ptr <= w_rd_ptr_nxt;
         end
         unique case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + CNT_WIDTH'(1);
            2'b01:   r_count <= r_count - CNT_WIDTH'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head word is shown as soon as the FIFO is non-empty
         assign data_out   = w_empty ? '0 : r_mem[r_rd_ptr];
         assign data_valid = ~w_empty;
      end else begin : g_std
         logic [FIFO_WIDTH-1:0] r_dout;
         logic                  r_dv;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               r_dout <= '0;
               r_dv   <= 1'b0;
            end else begin
               r_dv <= w_rd_acc;
               if (w_rd_acc) begin
                  r_dout <= r_mem[r_rd_ptr];
               end
            end
         end

         assign data_out   = r_dout;
         assign data_valid = r_dv;
      end
   endgenerate

   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (int'(r_count) >= AFULL_THRESH);
   assign almost_empty = (int'(r_count) <= AEMPTY_THRESH);
   assign count        = r_count;
   assign overflow     = r_ovf;
   assign underflow    = r_udf;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb_sync_fifo_flex: directed self-checking bench for sync_fifo_flex.
// Instances: depth 16 standard, depth 6 standard, depth 4 FWFT.
module tb_sync_fifo_flex;

   logic clk;
   logic rst_n;

   int n_chk;
   int n_fail;

   // depth 16, standard
   logic       a_we, a_re, a_dv, a_full, a_empty;
   logic       a_af, a_ae, a_ovf, a_udf;
   logic [7:0] a_din, a_dout;
   logic [4:0] a_cnt;

   // depth 6, standard
   logic       b_we, b_re, b_dv, b_full, b_empty;
   logic       b_af, b_ae, b_ovf, b_udf;
   logic [7:0] b_din, b_dout;
   logic [2:0] b_cnt;

   // depth 4, FWFT
   logic       c_we, c_re, c_dv, c_full, c_empty;
   logic       c_af, c_ae, c_ovf, c_udf;
   logic [7:0] c_din, c_dout;
   logic [2:0] c_cnt;

   logic [7:0] q[$];
   logic [7:0] exp_v;

   sync_fifo_flex #(.FIFO_DEPTH(16), .FIFO_WIDTH(8), .FWFT(0)) u_a (
      .clk(clk), .reset(rst_n),
      .write_en(a_we), .data_in(a_din),
      .read_en(a_re), .data_out(a_dout), .data_valid(a_dv),
      .full(a_full), .empty(a_empty),
      .almost_full(a_af), .almost_empty(a_ae),
      .count(a_cnt), .overflow(a_ovf), .underflow(a_udf)
   );

   sync_fifo_flex #(.FIFO_DEPTH(6), .FIFO_WIDTH(8), .FWFT(0)) u_b (
      .clk(clk), .reset(rst_n),
      .write_en(b_we), .data_in(b_din),
      .read_en(b_re), .data_out(b_dout), .data_valid(b_dv),
      .full(b_full), .empty(b_empty),
      .almost_full(b_af), .almost_empty(b_ae),
      .count(b_cnt), .overflow(b_ovf), .underflow(b_udf)
   );

   sync_fifo_flex #(.FIFO_DEPTH(4), .FIFO_WIDTH(8), .FWFT(1)) u_c (
      .clk(clk), .reset(rst_n),
      .write_en(c_we), .data_in(c_din),
      .read_en(c_re), .data_out(c_dout), .data_valid(c_dv),
      .full(c_full), .empty(c_empty),
      .almost_full(c_af), .almost_empty(c_ae),
      .count(c_cnt), .overflow(c_ovf), .underflow(c_udf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      a_we = 0; a_re = 0; a_din = 0;
      b_we = 0; b_re = 0; b_din = 0;
      c_we = 0; c_re = 0; c_din = 0;
      tick();
      tick();

      // reset state
      chk("rst_empty", a_empty, 1);
      chk("rst_full", a_full, 0);
      chk("rst_cnt", a_cnt, 0);
      chk("rst_dv", a_dv, 0);
      chk("rst_ae", a_ae, 1);
      chk("rst_af", a_af, 0);
      chk("rst_dout", a_dout, 0);
      chk("rst_ovf", a_ovf, 0);
      chk("rst_udf", a_udf, 0);
      chk("rst_fw_dv", c_dv, 0);
      chk("rst_fw_dout", c_dout, 0);

      @(negedge clk);
      rst_n = 1'b1;
      #1;

      // fill depth 16
      for (int i = 0; i < 16; i++) begin
         a_we  = 1;
         a_din = 8'(i + 1);
         tick();
         chk("fill_cnt", a_cnt, i + 1);
         chk("fill_af", a_af, (i + 1 >= 14) ? 1 : 0);
      end
      chk("full", a_full, 1);
      chk("full_ae", a_ae, 0);

      // overflow
      a_din = 8'hAA;
      tick();
      chk("ovf_pulse", a_ovf, 1);
      chk("ovf_cnt", a_cnt, 16);
      a_we = 0;
      tick();
      chk("ovf_clear", a_ovf, 0);
      chk("ovf_dv", a_dv, 0);

      // drain
      for (int i = 0; i < 16; i++) begin
         a_re = 1;
         tick();
         chk("drain_dv", a_dv, 1);
         chk("drain_data", a_dout, i + 1);
         chk("drain_ae", a_ae, (15 - i <= 2) ? 1 : 0);
      end
      a_re = 0;
      tick();
      chk("drain_empty", a_empty, 1);
      chk("drain_dv_low", a_dv, 0);

      // underflow
      a_re = 1;
      tick();
      chk("udf_pulse", a_udf, 1);
      chk("udf_hold", a_dout, 8'h10);
      chk("udf_dv", a_dv, 0);
      chk("udf_cnt", a_cnt, 0);
      a_re = 0;
      tick();
      chk("udf_clear", a_udf, 0);

      // count=5 then 40 cycles of read+write
      q.delete();
      for (int i = 0; i < 5; i++) begin
         a_we  = 1;
         a_din = 8'(8'h20 + i);
         q.push_back(a_din);
         tick();
      end
      chk("rw_pre_cnt", a_cnt, 5);
      for (int i = 0; i < 40; i++) begin
         a_we  = 1;
         a_re  = 1;
         a_din = 8'(8'h40 + i);
         exp_v = q.pop_front();
         q.push_back(a_din);
         tick();
         chk("rw_cnt", a_cnt, 5);
         chk("rw_data", a_dout, exp_v);
      end
      a_we = 0;
      for (int i = 0; i < 5; i++) begin
         a_re  = 1;
         exp_v = q.pop_front();
         tick();
         chk("rw_tail", a_dout, exp_v);
      end
      a_re = 0;
      tick();
      chk("rw_empty", a_empty, 1);

      // depth 6: offset pointers by one, then 3 fill/drain
      b_we = 1; b_din = 8'hF0;
      tick();
      b_we = 0; b_re = 1;
      tick();
      chk("d6_off", b_dout, 8'hF0);
      b_re = 0;
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 6; k++) begin
            b_we  = 1;
            b_din = 8'(r * 16 + k);
            tick();
         end
         b_we = 0;
         chk("d6_full", b_full, 1);
         chk("d6_cnt", b_cnt, 6);
         b_we = 1;
         tick();
         chk("d6_ovf", b_ovf, 1);
         b_we = 0;
         for (int k = 0; k < 6; k++) begin
            b_re = 1;
            tick();
            chk("d6_data", b_dout, r * 16 + k);
         end
         b_re = 0;
         tick();
         chk("d6_empty", b_empty, 1);
      end

      // FWFT
      c_we = 1; c_din = 8'h3C;
      tick();
      c_we = 0;
      chk("fw_dout", c_dout, 8'h3C);
      chk("fw_dv", c_dv, 1);
      tick();
      chk("fw_hold", c_dout, 8'h3C);
      c_re = 1;
      tick();
      c_re = 0;
      chk("fw_pop_empty", c_empty, 1);
      chk("fw_pop_dout", c_dout, 0);
      chk("fw_pop_dv", c_dv, 0);
      c_we = 1; c_din = 8'h11;
      tick();
      c_din = 8'h22;
      tick();
      c_we = 0;
      chk("fw_head1", c_dout, 8'h11);
      c_re = 1;
      tick();
      chk("fw_head2", c_dout, 8'h22);
      tick();
      c_re = 0;
      chk("fw_empty2", c_empty, 1);

      // async reset mid-stream at count 7
      for (int i = 0; i < 8; i++) begin
         a_we  = 1;
         a_din = 8'(8'h80 + i);
         tick();
      end
      a_we = 0;
      a_re = 1;
      tick();
      a_re = 0;
      chk("mid_cnt", a_cnt, 7);
      chk("mid_dv", a_dv, 1);
      chk("mid_data", a_dout, 8'h80);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_cnt", a_cnt, 0);
      chk("arst_empty", a_empty, 1);
      chk("arst_dv", a_dv, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      a_we = 1; a_din = 8'h55;
      tick();
      a_we = 0;
      chk("post_cnt", a_cnt, 1);
      a_re = 1;
      tick();
      a_re = 0;
      chk("post_data", a_dout, 8'h55);
      chk("post_dv", a_dv, 1);
      chk("post_empty", a_empty, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
